c_pair_seq_acc: RTL

C_PAIR_SEQ_ACC -- requirements
Module: c_pair_seq_acc

---
 rtl/c_pair_seq_acc.sv | 120 ++++++++++++
 1 files changed

// File: rtl/c_pair_seq_acc.sv
// c_pair_seq_acc: sweeps address pairs into a paired C-ROM stage and accumulates
// the LAT-cycle-delayed pair sums into a 23-bit total.
// Optional build macro C_PAIR_SEQ_ACC_MAX_EN adds max_pair, the largest valid
// result_in seen during the current sweep.
module c_pair_seq_acc #(
    parameter int unsigned LAT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [6:0]  base,
    input  logic [5:0]  npairs,
    output logic        ena,
    output logic [6:0]  adrC,
    output logic [6:0]  adrCnext,
    input  logic [16:0] result_in,
    output logic        busy,
    output logic        done,
    output logic [22:0] sum
`ifdef C_PAIR_SEQ_ACC_MAX_EN
    ,
    output logic [16:0] max_pair
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } state_e;

    state_e           state_q;
    // Pairs still to issue after the current one; npairs=0 loads 63, i.e. 64 pairs.
    logic [5:0]       cnt_q;
    logic [LAT-1:0]   vpipe_q;
    logic [LAT-1:0]   vpipe_d;
    logic             res_valid;

    assign res_valid = vpipe_q[LAT-1];

    // Valid pipe tracks which returning result_in samples belong to issued pairs.
    always_comb begin
        vpipe_d    = vpipe_q << 1;
        vpipe_d[0] = ena;
    end

    // Sweep FSM with registered outputs, valid pipe and accumulator.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            vpipe_q  <= '0;
            ena      <= 1'b0;
            adrC     <= '0;
            adrCnext <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
`ifdef C_PAIR_SEQ_ACC_MAX_EN
            max_pair <= '0;
`endif
        end else begin
            vpipe_q <= vpipe_d;
            if (res_valid) begin
                sum <= sum + {6'd0, result_in};
`ifdef C_PAIR_SEQ_ACC_MAX_EN
                if (result_in > max_pair) begin
                    max_pair <= result_in;
                end
`endif
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q  <= StIssue;
                        busy     <= 1'b1;
                        ena      <= 1'b1;
                        adrC     <= base;
                        adrCnext <= base + 7'd1;
                        cnt_q    <= npairs - 6'd1;
                        sum      <= '0;
`ifdef C_PAIR_SEQ_ACC_MAX_EN
                        max_pair <= '0;
`endif
                    end
                end
                StIssue: begin
                    if (cnt_q == 6'd0) begin
                        state_q  <= StDrain;
                        ena      <= 1'b0;
                        adrC     <= '0;
                        adrCnext <= '0;
                    end else begin
                        cnt_q    <= cnt_q - 6'd1;
                        adrC     <= adrC + 7'd2;
                        adrCnext <= adrC + 7'd3;
                    end
                end
                StDrain: begin
                    // Last result has been folded in once the pipe is empty.
                    if (vpipe_q == '0) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
